pipelined_sorter: RTL
=====================

# pipelined_sorter

Pipelined, parameterised N-lane sorter: accepts one vector of N unsigned DW-bit keys per cycle and emits the same keys fully sorted N cycles later. Supports per-transaction ascending/descending mode, valid/ready flow control with bubble collapsing, and an optional per-lane source-index output. It is the streaming successor to the combinational `parallel_sorter` and sits between a producing datapath and a consumer that may stall.

## Interface
- `N`, default 4: lane count; legal values are N ≥ 2, odd or even.
- `DW`, default 8: key width in bits.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  input vector present.
- `in_ready`  out  1  block can accept the input vector this cycle.
- `in_data`  in  DW*N  input keys; lane k occupies bits [DW*(k+1)-1 : DW*k].
- `in_desc`  in  1  0 = ascending (lane 0 holds the minimum), 1 = descending (lane 0 holds the maximum).
- `out_valid`  out  1  sorted vector present.
- `out_ready`  in  1  consumer accepts the output vector.
- `out_data`  out  DW*N  sorted keys, using the same lane layout as `in_data`.
- `out_idx`  out  IW*N  source lane of each output key, where IW = $clog2(N); present only with SORTER_IDX_EN.

## Operation
- Odd-even transposition network with N stages, one register stage per round. Stages are numbered s = 0..N-1.
- Even s: compare-exchange the lane pairs (0,1), (2,3), …
- Odd s: compare-exchange the lane pairs (1,2), (3,4), …
- An unpaired edge lane passes straight through its stage.
- Compare-exchange rule:
  - Ascending: swap only if lo > hi.
  - Descending: swap only if lo < hi.
  - Comparison is unsigned. Equal keys never swap, so the sort is stable.
- `in_desc` is captured together with the data and travels down the pipe with it. Mode may change on every transaction.
- Each stage holds a valid bit `v[s]`.
- Ready chain: `rdy[N] = out_ready`; `rdy[s] = !v[s] | rdy[s+1]`; `in_ready = rdy[0]`. The chain is combinational.
- Stage s loads when `rdy[s]` is high. It takes `v[s-1]` and the stage-(s-1) payload; stage 0 takes `in_valid` and `in_data`.
- Payload registers load only when the incoming valid is 1. Valid bits load on every enabled cycle.
- `out_valid = v[N-1]`. `out_data` and `out_idx` are driven directly from the last stage's registers.
- A transfer occurs on a cycle where valid & ready are both 1, on either side. No transaction is dropped or duplicated, and output order equals input order.
- Full condition: all `v` = 1 with `out_ready` = 0 drives `in_ready` = 0.
- Simultaneous accept and emit when full: if `out_ready` = 1, the whole pipe advances and a new input is accepted in the same cycle.

## Timing
- Reset: when `rst_n` = 0 at a clock edge, all `v` clear.
  - From the next cycle, `out_valid` = 0 and `in_ready` = 1.
  - Payload registers are not reset; `out_data` and `out_idx` are don't-care while `out_valid` = 0.
- Reset mid-operation discards every in-flight transaction. Inputs presented during reset are not captured.
- Latency: a transfer accepted at edge t appears with `out_valid` = 1 after edge t+N-1, i.e. N register stages. This holds with no stalls.
- Throughput: 1 vector per cycle while `out_ready` = 1.
- A stall holds `out_data` stable until it is accepted.
- Bubbles collapse: an empty stage accepts even when downstream is stalled.
- Combinational paths:
  - `out_ready` → `in_ready`: depth N.
  - Key compare: one DW-bit comparator per stage.

## Configuration
- `SORTER_IDX_EN` defined:
  - Each lane carries an IW-bit tag, initialised to the lane number at stage 0.
  - Tags swap together with their keys.
  - The `out_idx` port exists.
- Not defined:
  - No tag registers are built and the `out_idx` port is absent.
  - `out_data` and all timing are identical to the defined case.

## Structure
- Package `sorter_pkg`:
  - A lane-index width function, `idx_w(N)` = `$clog2(N)`.
  - A parity helper that selects even/odd pairing per stage.
- Sub-module `sort_cmp_swap`, combinational:
  - Parameter `DW`.
  - Inputs: lo/hi keys, the desc bit, and optional lo/hi tags.
  - Outputs: ordered keys and tags.
- The top instantiates the stages with generate loops.

## Test plan
- N=4, DW=8. Input lanes 0..3 = 02,04,01,03, `in_desc` = 0 → after 4 cycles lanes = 01,02,03,04 and `out_idx` = 2,0,3,1.
- Same keys with `in_desc` = 1 → lanes = 04,03,02,01 and `out_idx` = 1,3,0,2. Alternate the mode on back-to-back vectors; each output must follow its own mode.
- All lanes = 05 in both modes → `out_data` all 05 and `out_idx` = 0,1,2,3 (stability).
- Stream 8 random vectors back-to-back, hold `out_ready` = 0 for 6 cycles mid-stream:
  - `in_ready` falls once 4 transactions are held.
  - Every output matches the reference sort, in order, with no loss or duplication.
- Assert `rst_n` = 0 for one edge with 3 transactions in flight → `out_valid` = 0 and `in_ready` = 1 the next cycle, and none of the 3 transactions ever emerges.
- N=5 (odd), keys FF,00,80,7F,01 ascending → 00,01,7F,80,FF after 5 cycles.

Source files
------------

// File: rtl/sorter_pkg.sv
// Shared helpers for the pipelined odd-even transposition sorter.
// Lane-index width and the per-stage pairing rule live here so all files agree.
package sorter_pkg;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  // Even stages pair lanes from 0, odd stages from 1.
  function automatic int pair_base(input int s);
    return s % 2;
  endfunction

  function automatic bit is_pair_lo(input int s, input int k, input int n);
    return (k >= pair_base(s)) && (((k - pair_base(s)) % 2) == 0) && (k + 1 < n);
  endfunction

  function automatic bit is_pair_hi(input int s, input int k, input int n);
    return (k >= 1) && is_pair_lo(s, k - 1, n);
  endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// Single compare-exchange cell; tags follow their keys when SORTER_IDX_EN is defined.
// Equal keys never swap, which keeps the whole network stable.
module sort_cmp_swap #(
  parameter int DW = 8
`ifdef SORTER_IDX_EN
  , parameter int IW = 2
`endif
) (
  input  logic [DW-1:0] lo_key,
  input  logic [DW-1:0] hi_key,
  input  logic          desc,
`ifdef SORTER_IDX_EN
  input  logic [IW-1:0] lo_tag,
  input  logic [IW-1:0] hi_tag,
  output logic [IW-1:0] ord_lo_tag,
  output logic [IW-1:0] ord_hi_tag,
`endif
  output logic [DW-1:0] ord_lo_key,
  output logic [DW-1:0] ord_hi_key
);

  logic swap;

  assign swap       = desc ? (lo_key < hi_key) : (lo_key > hi_key);
  assign ord_lo_key = swap ? hi_key : lo_key;
  assign ord_hi_key = swap ? lo_key : hi_key;

`ifdef SORTER_IDX_EN
  assign ord_lo_tag = swap ? hi_tag : lo_tag;
  assign ord_hi_tag = swap ? lo_tag : hi_tag;
`endif

endmodule

// File: rtl/pipelined_sorter.sv
// N-stage pipelined odd-even transposition sorter with valid/ready flow control.
// Define SORTER_IDX_EN to carry per-lane source-index tags and expose out_idx.
module pipelined_sorter
  import sorter_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW*N-1:0] in_data,
  input  logic            in_desc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW*N-1:0] out_data
`ifdef SORTER_IDX_EN
  , output logic [idx_w(N)*N-1:0] out_idx
`endif
);

`ifdef SORTER_IDX_EN
  localparam int IW = idx_w(N);
`endif

  logic [N-1:0] v;
  logic [N-1:0] vin;
  logic [N:0]   rdy;

  // Handshake: a transfer happens on any edge where valid and ready are both
  // high; stage s may load whenever it is empty or the stage after it moves.
  always_comb begin
    rdy    = '0;
    rdy[N] = out_ready;
    for (int s = N - 1; s >= 0; s--) rdy[s] = !v[s] || rdy[s+1];
  end

  assign vin       = {v[N-2:0], in_valid};
  assign in_ready  = rdy[0];
  assign out_valid = v[N-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v <= '0;
    end else begin
      for (int s = 0; s < N; s++) begin
        if (rdy[s]) v[s] <= vin[s];
      end
    end
  end

  for (genvar s = 0; s < N; s++) begin : g_stage
    logic [DW-1:0] src_key [N];
    logic [DW-1:0] nxt_key [N];
    logic [DW-1:0] key_q   [N];
    logic          src_desc;
    logic          desc_q;
`ifdef SORTER_IDX_EN
    logic [IW-1:0] src_tag [N];
    logic [IW-1:0] nxt_tag [N];
    logic [IW-1:0] tag_q   [N];
`endif

    if (s == 0) begin : g_head
      for (genvar k = 0; k < N; k++) begin : g_src
        assign src_key[k] = in_data[DW*k +: DW];
`ifdef SORTER_IDX_EN
        assign src_tag[k] = IW'(k);
`endif
      end
      assign src_desc = in_desc;
    end else begin : g_body
      for (genvar k = 0; k < N; k++) begin : g_src
        assign src_key[k] = g_stage[s-1].key_q[k];
`ifdef SORTER_IDX_EN
        assign src_tag[k] = g_stage[s-1].tag_q[k];
`endif
      end
      assign src_desc = g_stage[s-1].desc_q;
    end

    for (genvar k = 0; k < N; k++) begin : g_lane
      if (is_pair_lo(s, k, N)) begin : g_cmp
        sort_cmp_swap #(
          .DW(DW)
`ifdef SORTER_IDX_EN
          , .IW(IW)
`endif
        ) u_cmp (
          .lo_key    (src_key[k]),
          .hi_key    (src_key[k+1]),
          .desc      (src_desc),
`ifdef SORTER_IDX_EN
          .lo_tag    (src_tag[k]),
          .hi_tag    (src_tag[k+1]),
          .ord_lo_tag(nxt_tag[k]),
          .ord_hi_tag(nxt_tag[k+1]),
`endif
          .ord_lo_key(nxt_key[k]),
          .ord_hi_key(nxt_key[k+1])
        );
      end else if (!is_pair_hi(s, k, N)) begin : g_pass
        assign nxt_key[k] = src_key[k];
`ifdef SORTER_IDX_EN
        assign nxt_tag[k] = src_tag[k];
`endif
      end
    end

    // Payload is not reset; only a valid incoming slot overwrites it.
    always_ff @(posedge clk) begin
      if (rdy[s] && vin[s]) begin
        key_q  <= nxt_key;
        desc_q <= src_desc;
`ifdef SORTER_IDX_EN
        tag_q  <= nxt_tag;
`endif
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_out
    assign out_data[DW*k +: DW] = g_stage[N-1].key_q[k];
`ifdef SORTER_IDX_EN
    assign out_idx[IW*k +: IW]  = g_stage[N-1].tag_q[k];
`endif
  end

endmodule
